// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit sequencer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam int          STUFF_RUN  = 6;
    localparam int          EOP_BITS   = 2;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    // The line shifter is LSB-first; reversing lets the CRC go out MSB-first.
    function automatic logic [15:0] bit_reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (x^16+x^15+x^2+1), one data bit per enabled cycle.
module usb_crc16 (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    import usb_tx_pkg::*;

    logic fb;

    assign fb = din ^ crc[15];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= CRC16_INIT;
        end else if (clr) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx_controller.sv
// USB full-speed packet sequencer: SYNC, PID, payload, CRC16, bit stuffing and EOP,
// one raw bit per bit period to the NRZI encoder.
//
// state | meaning
// IDLE  | waiting for tx_start
// SYNC  | sending 0x80 LSB first
// PID   | sending {~pid, pid} LSB first
// DATA  | sending payload bytes from the FIFO
// CRC   | sending inverted CRC16, MSB first
// EOP   | SE0 for EOP_BITS periods, then tx_done
module usb_tx_controller #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_has_data,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_pop,
    output logic       enc_data,
    output logic       enc_ready,
    output logic       enc_eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    import usb_tx_pkg::*;

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   shifter;
    logic [2:0]    ones_cnt;
    logic [3:0]    pid_q;
    logic          has_data_q;
    logic          last_q;

    logic        start_ok, period_end, field_done, stuff_now, load_byte;
    logic        emit, tx_bit, crc_en, crc_din;
    logic [7:0]  pid_byte;
    logic [15:0] crc, crc_tx;

    assign start_ok   = (state == ST_IDLE) && tx_start && !tx_done;
    assign period_end = (state != ST_IDLE) && (tick_cnt == '0);
    assign field_done = (bit_cnt == 4'd0);
    assign stuff_now  = period_end && (state != ST_EOP) && (ones_cnt == 3'(STUFF_RUN));
    assign load_byte  = period_end && !stuff_now && field_done &&
                        ((state == ST_PID && has_data_q) || (state == ST_DATA && !last_q));
    assign pid_byte   = {~pid_q, pid_q};
    assign crc_tx     = bit_reverse16(~crc);
    assign crc_en     = period_end && !stuff_now &&
                        ((state == ST_DATA && !field_done) || (load_byte && tx_valid));
    assign crc_din    = load_byte ? tx_byte[0] : shifter[0];

    usb_crc16 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (start_ok),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

    // Bit launched at the start of the next period (first bit of a field comes straight from its source).
    always_comb begin
        emit   = 1'b0;
        tx_bit = 1'b0;
        if (start_ok) begin
            emit   = 1'b1;
            tx_bit = SYNC_BYTE[0];
        end else if (period_end && state != ST_EOP) begin
            if (stuff_now) begin
                emit = 1'b1;
            end else if (!field_done) begin
                emit   = 1'b1;
                tx_bit = shifter[0];
            end else if (load_byte) begin
                emit   = tx_valid;
                tx_bit = tx_byte[0];
            end else if (state == ST_SYNC) begin
                emit   = 1'b1;
                tx_bit = pid_byte[0];
            end else if (state == ST_DATA) begin
                emit   = 1'b1;
                tx_bit = crc_tx[0];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shifter    <= '0;
            ones_cnt   <= '0;
            pid_q      <= '0;
            has_data_q <= 1'b0;
            last_q     <= 1'b0;
            tx_pop     <= 1'b0;
            enc_data   <= 1'b0;
            enc_ready  <= 1'b0;
            enc_eop    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            enc_ready <= emit;
            tx_pop    <= 1'b0;
            tx_err    <= 1'b0;
            tx_done   <= 1'b0;
            if (emit) begin
                enc_data <= tx_bit;
                ones_cnt <= tx_bit ? ones_cnt + 3'd1 : 3'd0;
            end
            if (state != ST_IDLE) begin
                tick_cnt <= period_end ? TICK_LAST : tick_cnt - TW'(1);
            end

            if (start_ok) begin
                state      <= ST_SYNC;
                pid_q      <= tx_pid;
                has_data_q <= tx_has_data;
                tick_cnt   <= TICK_LAST;
                tx_busy    <= 1'b1;
                shifter    <= {9'd0, SYNC_BYTE[7:1]};
                bit_cnt    <= 4'd7;
                ones_cnt   <= {2'b00, SYNC_BYTE[0]};
            end else if (period_end && state == ST_EOP) begin
                if (field_done) begin
                    state   <= ST_IDLE;
                    enc_eop <= 1'b0;
                    tx_done <= 1'b1;
                    tx_busy <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt - 4'd1;
                end
            end else if (period_end && !stuff_now) begin
                if (!field_done) begin
                    shifter <= shifter >> 1;
                    bit_cnt <= bit_cnt - 4'd1;
                end else if (load_byte && tx_valid) begin
                    state   <= ST_DATA;
                    shifter <= {9'd0, tx_byte[7:1]};
                    bit_cnt <= 4'd7;
                    last_q  <= tx_last;
                    tx_pop  <= 1'b1;
                end else if (state == ST_SYNC) begin
                    state   <= ST_PID;
                    shifter <= {9'd0, pid_byte[7:1]};
                    bit_cnt <= 4'd7;
                end else if (state == ST_DATA && last_q) begin
                    state   <= ST_CRC;
                    shifter <= {1'b0, crc_tx[15:1]};
                    bit_cnt <= 4'd15;
                end else begin
                    // Handshake end, CRC end, or a load that found the FIFO empty.
                    tx_err  <= load_byte;
                    state   <= ST_EOP;
                    enc_eop <= 1'b1;
                    bit_cnt <= 4'(EOP_BITS - 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_controller.sv
// Self-checking bench for usb_tx_controller against a packet-level reference model.
module tb_usb_tx_controller;
    import usb_tx_pkg::*;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'h0;
    logic       tx_has_data = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_valid, tx_last;
    logic       tx_pop, enc_data, enc_ready, enc_eop, tx_busy, tx_done, tx_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int t0 = 0;
    int rel;
    bit mon_en = 1'b0;
    int s_cyc[$];
    bit s_bit[$];
    int pop_cyc[$];
    int done_cyc[$];
    int err_n, eop_n, eop_first, busy_n, overlap_n;

    logic [7:0] fifo [16];
    int fifo_len = 0;
    bit fifo_last = 1'b0;
    bit fifo_rst = 1'b0;
    int fifo_idx = 0;

    bit e_bits[$];
    int e_pop[$];
    int e_stuffs;

    usb_tx_controller #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_start    (tx_start),
        .tx_pid      (tx_pid),
        .tx_has_data (tx_has_data),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_pop      (tx_pop),
        .enc_data    (enc_data),
        .enc_ready   (enc_ready),
        .enc_eop     (enc_eop),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (fifo_rst) fifo_idx <= 0;
        else if (tx_pop) fifo_idx <= fifo_idx + 1;
    end

    assign tx_valid = (fifo_idx < fifo_len);
    assign tx_byte  = fifo[fifo_idx[3:0]];
    assign tx_last  = fifo_last && (fifo_idx == fifo_len - 1);

    always @(negedge clk) begin
        if (mon_en) begin
            rel = cyc - t0;
            if (enc_ready) begin
                s_cyc.push_back(rel);
                s_bit.push_back(enc_data);
            end
            if (tx_pop) pop_cyc.push_back(rel);
            if (tx_done) done_cyc.push_back(rel);
            if (tx_err) err_n++;
            if (tx_busy) busy_n++;
            if (enc_eop) begin
                if (eop_n == 0) eop_first = rel;
                eop_n++;
            end
            if (enc_eop && enc_ready) overlap_n++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: raw field bits, then stuff a 0 after every run of six 1s.
    task automatic build_model(input logic [3:0] pid, input int nsent, input bit crc_on);
        bit raw[$];
        logic [7:0] sync_b, pid_b;
        logic [15:0] c;
        int run;
        sync_b = SYNC_BYTE;
        pid_b = {~pid, pid};
        c = 16'hFFFF;
        for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
        for (int i = 0; i < 8; i++) raw.push_back(pid_b[i]);
        for (int b = 0; b < nsent; b++) begin
            for (int i = 0; i < 8; i++) begin
                raw.push_back(fifo[b][i]);
                c = {c[14:0], 1'b0} ^ ((fifo[b][i] ^ c[15]) ? 16'h8005 : 16'h0000);
            end
        end
        if (crc_on) for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
        e_bits.delete();
        e_pop.delete();
        e_stuffs = 0;
        run = 0;
        for (int k = 0; k < raw.size(); k++) begin
            if (k >= 16 && k < 16 + 8 * nsent && (k - 16) % 8 == 0) e_pop.push_back(e_bits.size());
            e_bits.push_back(raw[k]);
            run = raw[k] ? run + 1 : 0;
            if (run == 6) begin
                e_bits.push_back(1'b0);
                e_stuffs++;
                run = 0;
            end
        end
    endtask

    task automatic load_fifo(input int len, input bit last);
        fifo_len = len;
        fifo_last = last;
        fifo_rst = 1'b1;
        @(posedge clk);
        #1 fifo_rst = 1'b0;
    endtask

    task automatic start_pkt(input logic [3:0] pid, input bit hd);
        s_cyc.delete(); s_bit.delete(); pop_cyc.delete(); done_cyc.delete();
        err_n = 0; eop_n = 0; eop_first = -1; busy_n = 0; overlap_n = 0;
        @(negedge clk);
        tx_pid = pid;
        tx_has_data = hd;
        tx_start = 1'b1;
        t0 = cyc;
        mon_en = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int tail);
        for (int i = 0; i < budget && done_cyc.size() == 0; i++) @(negedge clk);
        repeat (tail) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_pop, enc_data, enc_ready, enc_eop, tx_busy, tx_done, tx_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {tx_pop, enc_data, enc_ready, enc_eop, tx_busy, tx_done, tx_err});
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_pop, enc_ready, enc_eop, tx_busy, tx_done, tx_err} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, expected 000000",
                     {tx_pop, enc_ready, enc_eop, tx_busy, tx_done, tx_err});
        end
    endtask

    task automatic test_ack;
        int nbad;
        logic [15:0] obs;
        build_model(PID_ACK, 0, 0);
        start_pkt(PID_ACK, 1'b0);
        wait_done(400, 3 * C);
        nbad = 0;
        obs = '0;
        foreach (s_cyc[k]) begin
            if (k < 16) obs[k] = s_bit[k];
            if (k >= e_bits.size() || s_bit[k] != e_bits[k] || s_cyc[k] != 1 + k * C) nbad++;
        end
        checks++;
        if (nbad != 0 || s_cyc.size() != e_bits.size()) begin
            errors++;
            $display("FAIL ack_stream: %0d strobes, %0d wrong, expected %0d", s_cyc.size(), nbad, e_bits.size());
        end
        checks++;
        if (obs !== 16'hD280 || s_cyc.size() != 16) begin
            errors++;
            $display("FAIL ack_bits: got %h (%0d strobes), expected d280 (16)", obs, s_cyc.size());
        end
        checks++;
        if (eop_first != 65 || eop_n != 8 || overlap_n != 0) begin
            errors++;
            $display("FAIL ack_eop: first %0d len %0d overlap %0d, expected 65 8 0", eop_first, eop_n, overlap_n);
        end
        checks++;
        if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != 73)) begin
            errors++;
            $display("FAIL ack_done: %0d pulses first at %0d, expected 1 at 73",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
        checks++;
        if (busy_n != 72 || pop_cyc.size() != 0 || err_n != 0) begin
            errors++;
            $display("FAIL ack_misc: busy %0d pops %0d errs %0d, expected 72 0 0", busy_n, pop_cyc.size(), err_n);
        end
    endtask

    task automatic test_data0_zero;
        int nbad;
        fifo[0] = 8'h00;
        load_fifo(1, 1'b1);
        build_model(PID_DATA0, 1, 1'b1);
        start_pkt(PID_DATA0, 1'b1);
        wait_done(1000, 3 * C);
        nbad = 0;
        foreach (s_cyc[k])
            if (k >= e_bits.size() || s_bit[k] != e_bits[k] || s_cyc[k] != 1 + k * C) nbad++;
        checks++;
        if (nbad != 0 || s_cyc.size() != e_bits.size()) begin
            errors++;
            $display("FAIL data0_stream: %0d strobes, %0d wrong, expected %0d", s_cyc.size(), nbad, e_bits.size());
        end
        checks++;
        if (pop_cyc.size() != 1 || (pop_cyc.size() == 1 && pop_cyc[0] != 1 + e_pop[0] * C)) begin
            errors++;
            $display("FAIL data0_pop: %0d pops first at %0d, expected 1 at %0d",
                     pop_cyc.size(), pop_cyc.size() > 0 ? pop_cyc[0] : -1, 1 + e_pop[0] * C);
        end
        checks++;
        if (done_cyc.size() != 1 || eop_n != 2 * C || err_n != 0 ||
            (done_cyc.size() == 1 && done_cyc[0] != 1 + (e_bits.size() + 2) * C)) begin
            errors++;
            $display("FAIL data0_done: %0d pulses eop %0d err %0d, expected 1 at %0d",
                     done_cyc.size(), eop_n, err_n, 1 + (e_bits.size() + 2) * C);
        end
    endtask

    task automatic test_data1_ff;
        int nbad, run, nst;
        fifo[0] = 8'hFF;
        fifo[1] = 8'hFF;
        load_fifo(2, 1'b1);
        build_model(PID_DATA1, 2, 1'b1);
        start_pkt(PID_DATA1, 1'b1);
        wait_done(1000, 3 * C);
        nbad = 0;
        run = 0;
        nst = 0;
        foreach (s_cyc[k]) begin
            if (k >= e_bits.size() || s_bit[k] != e_bits[k] || s_cyc[k] != 1 + k * C) nbad++;
            if (run == 6) begin
                nst++;
                run = 0;
            end else begin
                run = s_bit[k] ? run + 1 : 0;
            end
        end
        checks++;
        if (nbad != 0 || s_cyc.size() != e_bits.size()) begin
            errors++;
            $display("FAIL data1_stream: %0d strobes, %0d wrong, expected %0d", s_cyc.size(), nbad, e_bits.size());
        end
        checks++;
        if (nst != e_stuffs) begin
            errors++;
            $display("FAIL data1_stuffs: got %0d stuffed bits, expected %0d", nst, e_stuffs);
        end
        nbad = 0;
        foreach (pop_cyc[b]) if (b >= e_pop.size() || pop_cyc[b] != 1 + e_pop[b] * C) nbad++;
        checks++;
        if (pop_cyc.size() != 2 || nbad != 0 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL data1_pops: %0d pops (%0d mistimed) %0d done, expected 2 0 1",
                     pop_cyc.size(), nbad, done_cyc.size());
        end
    endtask

    task automatic test_random_data;
        int nbad, pbad, n;
        logic [3:0] pid;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 6));
            pid = ($urandom_range(0, 1) == 0) ? PID_DATA0 : PID_DATA1;
            for (int b = 0; b < n; b++) fifo[b] = 8'($urandom);
            if (it == 0) fifo[0] = 8'hFE;
            load_fifo(n, 1'b1);
            build_model(pid, n, 1'b1);
            start_pkt(pid, 1'b1);
            wait_done(4000, 3 * C);
            nbad = 0;
            foreach (s_cyc[k])
                if (k >= e_bits.size() || s_bit[k] != e_bits[k] || s_cyc[k] != 1 + k * C) nbad++;
            pbad = 0;
            foreach (pop_cyc[b]) if (b >= e_pop.size() || pop_cyc[b] != 1 + e_pop[b] * C) pbad++;
            checks++;
            if (nbad != 0 || s_cyc.size() != e_bits.size()) begin
                errors++;
                $display("FAIL rand_stream[%0d]: %0d strobes, %0d wrong, expected %0d",
                         it, s_cyc.size(), nbad, e_bits.size());
            end
            checks++;
            if (pbad != 0 || pop_cyc.size() != n) begin
                errors++;
                $display("FAIL rand_pops[%0d]: %0d pops, %0d mistimed, expected %0d", it, pop_cyc.size(), pbad, n);
            end
            checks++;
            if (done_cyc.size() != 1 || overlap_n != 0 ||
                (done_cyc.size() == 1 && done_cyc[0] != 1 + (e_bits.size() + 2) * C)) begin
                errors++;
                $display("FAIL rand_done[%0d]: %0d pulses, overlap %0d, expected 1 at %0d",
                         it, done_cyc.size(), overlap_n, 1 + (e_bits.size() + 2) * C);
            end
        end
    endtask

    task automatic test_underrun;
        int nbad, ef;
        fifo[0] = 8'($urandom);
        load_fifo(1, 1'b0);
        build_model(PID_DATA0, 1, 1'b0);
        start_pkt(PID_DATA0, 1'b1);
        wait_done(1000, 3 * C);
        ef = 1 + e_bits.size() * C;
        nbad = 0;
        foreach (s_cyc[k])
            if (k >= e_bits.size() || s_bit[k] != e_bits[k] || s_cyc[k] != 1 + k * C) nbad++;
        checks++;
        if (nbad != 0 || s_cyc.size() != e_bits.size()) begin
            errors++;
            $display("FAIL underrun_stream: %0d strobes, %0d wrong, expected %0d", s_cyc.size(), nbad, e_bits.size());
        end
        checks++;
        if (err_n != 1 || pop_cyc.size() != 1) begin
            errors++;
            $display("FAIL underrun_err: %0d err pulses %0d pops, expected 1 1", err_n, pop_cyc.size());
        end
        checks++;
        if (eop_first != ef || eop_n != 2 * C || done_cyc.size() != 1 ||
            (done_cyc.size() == 1 && done_cyc[0] != ef + 2 * C)) begin
            errors++;
            $display("FAIL underrun_eop: eop %0d len %0d done pulses %0d, expected eop %0d len %0d",
                     eop_first, eop_n, done_cyc.size(), ef, 2 * C);
        end
    endtask

    task automatic test_start_while_busy;
        int nbad;
        build_model(PID_ACK, 0, 0);
        start_pkt(PID_ACK, 1'b0);
        while (cyc - t0 < 20) @(negedge clk);
        tx_pid = PID_NAK;
        tx_start = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
        wait_done(400, 100);
        nbad = 0;
        foreach (s_cyc[k])
            if (k >= e_bits.size() || s_bit[k] != e_bits[k] || s_cyc[k] != 1 + k * C) nbad++;
        checks++;
        if (nbad != 0 || s_cyc.size() != e_bits.size()) begin
            errors++;
            $display("FAIL busy_start_stream: %0d strobes, %0d wrong, expected %0d", s_cyc.size(), nbad, e_bits.size());
        end
        checks++;
        if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != 73)) begin
            errors++;
            $display("FAIL busy_start_done: %0d pulses, expected 1 at 73", done_cyc.size());
        end
    endtask

    task automatic test_reset_mid_data;
        int nbad;
        for (int b = 0; b < 4; b++) fifo[b] = 8'($urandom);
        load_fifo(4, 1'b1);
        start_pkt(PID_DATA0, 1'b1);
        while (cyc - t0 < 90) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({tx_pop, enc_data, enc_ready, enc_eop, tx_busy, tx_done, tx_err} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, expected 0000000",
                     {tx_pop, enc_data, enc_ready, enc_eop, tx_busy, tx_done, tx_err});
        end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (10 * C) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (done_cyc.size() != 0 || eop_n != 0) begin
            errors++;
            $display("FAIL midreset_abort: %0d done pulses, %0d eop cycles, expected 0 0", done_cyc.size(), eop_n);
        end
        load_fifo(0, 1'b0);
        build_model(PID_ACK, 0, 0);
        start_pkt(PID_ACK, 1'b0);
        wait_done(400, 3 * C);
        nbad = 0;
        foreach (s_cyc[k])
            if (k >= e_bits.size() || s_bit[k] != e_bits[k] || s_cyc[k] != 1 + k * C) nbad++;
        checks++;
        if (nbad != 0 || s_cyc.size() != e_bits.size() || eop_first != 65 || done_cyc.size() != 1 ||
            (done_cyc.size() == 1 && done_cyc[0] != 73)) begin
            errors++;
            $display("FAIL midreset_ack: %0d strobes (%0d wrong) eop %0d done %0d, expected %0d 0 65 1",
                     s_cyc.size(), nbad, eop_first, done_cyc.size(), e_bits.size());
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0_zero();
        test_data1_ff();
        test_random_data();
        test_underrun();
        test_start_while_busy();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
